// File: rtl/tug_scorer_n.sv
// Tug-of-war scorer: walks a marker across 2*STEPS+1 LEDs, shows a held round-win
// pattern, re-centres, and tracks round wins until one player takes the match.
module tug_scorer_n #(
    parameter int STEPS         = 3,
    parameter int FAVOR_LOSER   = 1,
    parameter int ROUNDS_TO_WIN = 2,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 winrnd,
    input  logic                                 right,
    input  logic                                 tie,
    input  logic                                 leds_on,
    output logic [2*STEPS:0]                     score,
    output logic                                 round_win,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   wins_l,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0]   wins_r,
    output logic                                 match_done,
    output logic                                 winner_left
);

    localparam int N  = 2*STEPS + 1;
    localparam int W  = $clog2(ROUNDS_TO_WIN + 1);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    // Two spare bits so p +/- 2 never wraps before the range check.
    localparam int PW = $clog2(STEPS + 1) + 2;

    typedef logic [N-1:0] score_t;
    typedef enum logic [1:0] {PLAY = 2'd0, HOLD = 2'd1, DONE = 2'd2} state_t;

    localparam score_t ONES      = '1;
    localparam score_t LEFT_PAT  = ONES << (STEPS + 1);
    localparam score_t RIGHT_PAT = ONES >> (STEPS + 1);

    localparam logic signed [PW-1:0] SMAX = PW'(STEPS);
    localparam logic signed [PW-1:0] SMIN = -SMAX;
    localparam logic signed [PW-1:0] ONE  = PW'(1);
    localparam logic [W-1:0]         RTW  = W'(ROUNDS_TO_WIN);
    localparam logic [W-1:0]         WONE = W'(1);
    localparam logic [TW-1:0]        TLOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]        TONE  = TW'(1);

    function automatic score_t pos_pattern(input logic signed [PW-1:0] pos);
        int idx = STEPS - int'(pos);
        return score_t'(1) << idx;
    endfunction

    state_t                 state;
    logic signed [PW-1:0]   p;
    logic [TW-1:0]          timer;

    logic                   mr;
    logic                   fav;
    logic                   win_now;
    logic signed [PW-1:0]   d;
    logic signed [PW-1:0]   p_step;
    logic signed [PW-1:0]   p_next;

    always_comb begin
        mr      = (right & leds_on) | (~right & ~leds_on);
        d       = mr ? ONE : -ONE;
        p_step  = p + d;
        // Catch-up move only when pinned at an edge and pushing back toward centre.
        fav     = (FAVOR_LOSER != 0) && leds_on &&
                  ((p == SMAX && !mr) || (p == SMIN && mr));
        p_next  = fav ? (p_step + d) : p_step;
        win_now = !fav && ((p_step > SMAX) || (p_step < SMIN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PLAY;
            p           <= '0;
            timer       <= '0;
            score       <= pos_pattern('0);
            round_win   <= 1'b0;
            wins_l      <= '0;
            wins_r      <= '0;
            match_done  <= 1'b0;
            winner_left <= 1'b0;
        end else begin
            round_win <= 1'b0;
            case (state)
                PLAY: begin
                    if (winrnd && !tie) begin
                        if (win_now) begin
                            state       <= HOLD;
                            timer       <= TLOAD;
                            round_win   <= 1'b1;
                            winner_left <= !mr;
                            if (mr) begin
                                score <= RIGHT_PAT;
                                if (wins_r != RTW) wins_r <= wins_r + WONE;
                            end else begin
                                score <= LEFT_PAT;
                                if (wins_l != RTW) wins_l <= wins_l + WONE;
                            end
                        end else begin
                            p     <= p_next;
                            score <= pos_pattern(p_next);
                        end
                    end
                end
                HOLD: begin
                    if (timer == '0) begin
                        if ((winner_left ? wins_l : wins_r) == RTW) begin
                            state      <= DONE;
                            match_done <= 1'b1;
                        end else begin
                            state <= PLAY;
                            p     <= '0;
                            score <= pos_pattern('0);
                        end
                    end else begin
                        timer <= timer - TONE;
                    end
                end
                DONE: begin
                end
                default: begin
                    state <= PLAY;
                    p     <= '0;
                    score <= pos_pattern('0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tug_scorer_n.sv
// Bench for tug_scorer_n: directed vector table, a favour-loser A/B sequence,
// and randomized play checked against an abstract game model.
module tb_tug_scorer_n;

    localparam int S   = 3;
    localparam int N   = 2*S + 1;
    localparam int H   = 8;
    localparam int RTW = 2;
    localparam int W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0, winrnd = 1'b0, right = 1'b0, tie = 1'b0, leds_on = 1'b0;

    logic [N-1:0] score_a, score_b;
    logic         rw_a, rw_b, md_a, md_b, wlf_a, wlf_b;
    logic [W-1:0] wl_a, wr_a, wl_b, wr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tug_scorer_n dut_a (
        .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie), .leds_on(leds_on),
        .score(score_a), .round_win(rw_a), .wins_l(wl_a), .wins_r(wr_a),
        .match_done(md_a), .winner_left(wlf_a)
    );

    tug_scorer_n #(.FAVOR_LOSER(0)) dut_b (
        .clk(clk), .rst(rst), .winrnd(winrnd), .right(right), .tie(tie), .leds_on(leds_on),
        .score(score_b), .round_win(rw_b), .wins_l(wl_b), .wins_r(wr_b),
        .match_done(md_b), .winner_left(wlf_b)
    );

    // Game model: phase 0 = playing, 1 = showing a round win, 2 = match over.
    typedef struct {
        int pos;
        int phase;
        int hold_left;
        int wl;
        int wr;
        bit wleft;
        bit rw;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(input mdl_t m, input bit fav,
                                   input bit rs, input bit w, input bit r,
                                   input bit t, input bit l);
        mdl_t n;
        int   dir;
        n    = m;
        n.rw = 1'b0;
        if (rs) begin
            n = '{0, 0, 0, 0, 0, 1'b0, 1'b0};
            return n;
        end
        if (m.phase == 1) begin
            n.hold_left = m.hold_left - 1;
            if (n.hold_left == 0) begin
                if ((m.wleft ? m.wl : m.wr) == RTW) n.phase = 2;
                else begin
                    n.phase = 0;
                    n.pos   = 0;
                end
            end
            return n;
        end
        if (m.phase == 2 || !w || t) return n;
        dir = ((r && l) || (!r && !l)) ? 1 : -1;
        if (fav && l && (m.pos == -dir * S)) begin
            n.pos = m.pos + 2 * dir;
        end else if (m.pos + dir > S || m.pos + dir < -S) begin
            n.phase     = 1;
            n.hold_left = H;
            n.rw        = 1'b1;
            n.wleft     = (dir < 0);
            if (dir < 0) n.wl = (m.wl + 1 > RTW) ? RTW : m.wl + 1;
            else         n.wr = (m.wr + 1 > RTW) ? RTW : m.wr + 1;
        end else begin
            n.pos = m.pos + dir;
        end
        return n;
    endfunction

    function automatic logic [N-1:0] mscore(input mdl_t m);
        logic [N-1:0] one = 7'd1;
        if (m.phase == 0) return one << (S - m.pos);
        return m.wleft ? 7'b1110000 : 7'b0000111;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rs, input bit w, input bit r, input bit t, input bit l);
        rst = rs; winrnd = w; right = r; tie = t; leds_on = l;
        @(posedge clk);
        ma = mstep(ma, 1'b1, rs, w, r, t, l);
        mb = mstep(mb, 1'b0, rs, w, r, t, l);
        #1;
    endtask

    task automatic cmp_model(input string tag, input mdl_t m, input logic [N-1:0] sc,
                             input logic rw, input logic [W-1:0] wl, input logic [W-1:0] wr,
                             input logic md, input logic wlf);
        chk({tag, ".score"}, int'(sc), int'(mscore(m)));
        chk({tag, ".round_win"}, int'(rw), int'(m.rw));
        chk({tag, ".wins_l"}, int'(wl), m.wl);
        chk({tag, ".wins_r"}, int'(wr), m.wr);
        chk({tag, ".match_done"}, int'(md), (m.phase == 2) ? 1 : 0);
        chk({tag, ".winner_left"}, int'(wlf), int'(m.wleft));
    endtask

    typedef struct {
        bit           rs, w, r, t, l;
        logic [N-1:0] sc;
        bit           rw;
        int           wl, wr;
        bit           md, wlf;
    } vec_t;

    vec_t tab[$];

    function automatic void add(input bit rs, input bit w, input bit r, input bit t, input bit l,
                                input logic [N-1:0] sc, input bit rw, input int wl, input int wr,
                                input bit md, input bit wlf);
        vec_t v;
        v = '{rs, w, r, t, l, sc, rw, wl, wr, md, wlf};
        tab.push_back(v);
    endfunction

    initial begin
        // Reset, three right pushes, right round win, held 8 cycles.
        add(1,0,0,0,0, 7'b0001000, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000100, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000010, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000001, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000111, 1, 0,1, 0,0);
        for (int i = 0; i < 7; i++) add(0,0,0,0,0, 7'b0000111, 0, 0,1, 0,0);
        // Push landing on the hold-expiry cycle is dropped.
        add(0,1,1,0,1, 7'b0001000, 0, 0,1, 0,0);
        add(0,1,1,1,1, 7'b0001000, 0, 0,1, 0,0);
        add(0,1,0,0,1, 7'b0010000, 0, 0,1, 0,0);
        add(0,1,0,0,1, 7'b0100000, 0, 0,1, 0,0);
        add(0,1,0,0,1, 7'b1000000, 0, 0,1, 0,0);
        add(0,1,0,1,0, 7'b1000000, 0, 0,1, 0,0);
        add(0,1,1,0,1, 7'b0010000, 0, 0,1, 0,0);
        // Jumped light by the right player moves the marker left.
        add(0,1,1,0,0, 7'b0100000, 0, 0,1, 0,0);
        add(0,1,1,0,0, 7'b1000000, 0, 0,1, 0,0);
        add(0,1,1,0,0, 7'b1110000, 1, 1,1, 0,1);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) add(0,1,1,0,1, 7'b1110000, 0, 1,1, 0,1);
            else        add(0,0,0,0,0, 7'b1110000, 0, 1,1, 0,1);
        end
        add(0,0,0,0,0, 7'b0001000, 0, 1,1, 0,1);
        add(0,1,0,0,1, 7'b0010000, 0, 1,1, 0,1);
        add(0,1,0,0,1, 7'b0100000, 0, 1,1, 0,1);
        add(0,1,0,0,1, 7'b1000000, 0, 1,1, 0,1);
        add(0,1,0,0,1, 7'b1110000, 1, 2,1, 0,1);
        for (int i = 0; i < 7; i++) add(0,0,0,0,0, 7'b1110000, 0, 2,1, 0,1);
        add(0,0,0,0,0, 7'b1110000, 0, 2,1, 1,1);
        add(0,1,1,0,1, 7'b1110000, 0, 2,1, 1,1);
        add(0,1,0,0,0, 7'b1110000, 0, 2,1, 1,1);
        // Reset out of DONE, then reset mid-HOLD with a competing push.
        add(1,0,0,0,0, 7'b0001000, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000100, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000010, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000001, 0, 0,0, 0,0);
        add(0,1,1,0,1, 7'b0000111, 1, 0,1, 0,0);
        add(0,0,0,0,0, 7'b0000111, 0, 0,1, 0,0);
        add(1,1,1,0,1, 7'b0001000, 0, 0,0, 0,0);
        add(0,0,0,0,0, 7'b0001000, 0, 0,0, 0,0);

        foreach (tab[i]) begin
            step(tab[i].rs, tab[i].w, tab[i].r, tab[i].t, tab[i].l);
            chk($sformatf("vec%0d.score", i), int'(score_a), int'(tab[i].sc));
            chk($sformatf("vec%0d.round_win", i), int'(rw_a), int'(tab[i].rw));
            chk($sformatf("vec%0d.wins_l", i), int'(wl_a), tab[i].wl);
            chk($sformatf("vec%0d.wins_r", i), int'(wr_a), tab[i].wr);
            chk($sformatf("vec%0d.match_done", i), int'(md_a), int'(tab[i].md));
            chk($sformatf("vec%0d.winner_left", i), int'(wlf_a), int'(tab[i].wlf));
        end

        // Favour-loser on vs off from the far-left position.
        step(1,0,0,0,0);
        for (int i = 0; i < 3; i++) step(0,1,0,0,1);
        chk("fav_pre_a", int'(score_a), int'(7'b1000000));
        chk("fav_pre_b", int'(score_b), int'(7'b1000000));
        step(0,1,1,0,1);
        chk("fav_on", int'(score_a), int'(7'b0010000));
        chk("fav_off", int'(score_b), int'(7'b0100000));

        // Randomized play against the model, both variants.
        step(1,0,0,0,0);
        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 149) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0);
            cmp_model("rand_a", ma, score_a, rw_a, wl_a, wr_a, md_a, wlf_a);
            cmp_model("rand_b", mb, score_b, rw_b, wl_b, wr_b, md_b, wlf_b);
            if (ma.phase == 2 && $urandom_range(0, 15) == 0) step(1,0,0,0,0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_scorer_n.md
# tug_scorer_n

Parametrised tug-of-war scoring engine for the push-button reaction game. It consumes the per-round arbitration pulse (`winrnd`, `right`, `tie`) and the light status (`leds_on`), and moves a marker across `2*STEPS+1` LED positions. It counts round wins per player and declares a match winner after `ROUNDS_TO_WIN` rounds. It replaces the fixed 3-step, single-round scorer: depth is generalised, favour-the-loser is optional, and it adds an automatic win-hold/re-centre sequence and match tracking.

## Interface
- `STEPS`, default 3: positions per side, excluding centre; legal range ≥ 2.
- `FAVOR_LOSER`, default 1: enables the 2-step catch-up move on proper pushes.
- `ROUNDS_TO_WIN`, default 2: round wins needed to end the match; ≥ 1.
- `HOLD_CYCLES`, default 8: cycles the round-win pattern is shown before re-centring; ≥ 1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `winrnd`  in  1: one-cycle pulse, someone pushed.
- `right`  in  1: the right player pushed first; valid with `winrnd`.
- `tie`  in  1: simultaneous push; valid with `winrnd`.
- `leds_on`  in  1: lights were on at the push, i.e. a proper push; 0 means the light was jumped.
- `score`  out  2*STEPS+1: display. The MSB is the far-left position, and bit `STEPS` is centre.
- `round_win`  out  1: one-cycle pulse when a round is won.
- `wins_l`, `wins_r`  out  W = $clog2(ROUNDS_TO_WIN+1): round-win counters.
- `match_done`  out  1: level, high once the match is decided.
- `winner_left`  out  1: valid while `match_done`; 1 means left won the match.

## Operation
- Internal signed position `p` in −STEPS..+STEPS. Negative values are the left side, and 0 is centre.
- `mr = (right & leds_on) | (~right & ~leds_on)`: a proper right push or a jumped left push moves the marker right.
- States:
  - PLAY: marker active.
  - HOLD: win pattern shown, timer running.
  - DONE: match decided.
- PLAY, `winrnd & tie`: no change.
- PLAY, `winrnd & ~tie`, computing the nominal move `d = mr ? +1 : −1`:
  - If `FAVOR_LOSER`, `leds_on`, `|p| == STEPS`, and `d` points toward centre: move 2 steps. For example, −STEPS → −STEPS+2.
  - If `p + d` exceeds ±STEPS: round won by that side. Increment `wins_l` or `wins_r`, pulse `round_win`, load the hold timer with HOLD_CYCLES−1, and go to HOLD.
  - Otherwise `p ← p + d`.
- HOLD: `winrnd` is ignored and the timer decrements.
  - At timer 0, if the winner's counter equals ROUNDS_TO_WIN: go to DONE and set `match_done`. `winner_left` is already latched at round win.
  - Otherwise: `p ← 0` and go to PLAY.
- DONE: all inputs ignored until `rst`. `score` holds the winner pattern.
- `score` in PLAY: one-hot with bit `STEPS − p` set.
- `score` in HOLD and DONE:
  - Left win: bits [2*STEPS:STEPS+1] set, rest 0.
  - Right win: bits [STEPS−1:0] set, rest 0.
- An illegal encoded state recovers to PLAY with `p = 0` on the next edge; counters are unchanged.
- Win counters saturate at ROUNDS_TO_WIN and never wrap.

## Timing
- Reset values: `p = 0`, state PLAY, `score` = only bit STEPS set, `round_win = 0`, `wins_l = wins_r = 0`, `match_done = 0`, `winner_left = 0`.
- All outputs are registered.
- A `winrnd` sampled at edge k is reflected on `score` after edge k. `round_win` is high for the cycle after edge k only.
- HOLD lasts exactly HOLD_CYCLES cycles. `score` returns to centre, or `match_done` rises, on the following cycle.
- `winrnd` arriving in the same cycle the HOLD timer expires is dropped.
- `rst` during HOLD or DONE forces the full reset values on the next edge; a pending hold is discarded.
- `rst` has priority over a simultaneous `winrnd`.

## Test plan
- Reset, STEPS=3: `score` = 0001000, all counters 0, `match_done` = 0.
- From centre, three proper right pushes (`right=1`, `leds_on=1`):
  - `score` steps through 0000100, 0000010, 0000001.
  - A fourth push gives 0000111, a `round_win` pulse, and `wins_r` = 1.
  - After 8 cycles `score` = 0001000.
- Favour-loser, from p = −3 (1000000): a proper right push gives 0010000. With FAVOR_LOSER=0 the same push gives 0100000.
- Jumped light from p = −3: `right=1`, `leds_on=0` (left moves toward left) gives the left win pattern 1110000. A `tie` pulse at any position leaves `score` unchanged.
- Two left round wins with ROUNDS_TO_WIN=2: `wins_l` = 2, `match_done` = 1, `winner_left` = 1, and later pushes are ignored.
- `rst` asserted mid-HOLD: the next cycle shows `score` = 0001000, `wins_*` = 0, no `round_win`.
